// File: rtl/tx_frame_scheduler_pkg.sv
// Shared constants for the Tx frame scheduler: modulation mode encodings,
// FSM state encoding, reset defaults and the legal-mode check.
package tx_frame_scheduler_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [3:0]  DEF_MODE_C  = MODE_MIX;
    localparam logic [3:0]  DEF_DELAY_C = 4'd8;
    localparam logic [15:0] DEF_PHASE_C = 16'd8192;

    function automatic logic mode_is_valid(input logic [3:0] m);
        return (m == MODE_BPSK) || (m == MODE_QPSK) || (m == MODE_MIX);
    endfunction

endpackage

// File: rtl/tx_cfg_shadow.sv
// Configuration request intake: valid/ready handshake, legal-mode check and
// shadow register holding one accepted request until the scheduler applies it.
// Ports: clk_i/rst_i (sync, active-high); cfg_valid_i, cfg_mode_i,
// cfg_delay_i, cfg_phase_i request; apply_i consumes shadow; cfg_ready_o,
// pending_o, cfg_err_o (reject pulse), mode_o/delay_o/phase_o shadow contents.
module tx_cfg_shadow
    import tx_frame_scheduler_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_valid_i,
    input  logic [3:0]  cfg_mode_i,
    input  logic [3:0]  cfg_delay_i,
    input  logic [15:0] cfg_phase_i,
    input  logic        apply_i,
    output logic        cfg_ready_o,
    output logic        pending_o,
    output logic        cfg_err_o,
    output logic [3:0]  mode_o,
    output logic [3:0]  delay_o,
    output logic [15:0] phase_o
);

    logic        pend_q, pend_d;
    logic        err_q;
    logic [3:0]  mode_q, delay_q;
    logic [15:0] phase_q;
    logic        accept, legal;

    assign cfg_ready_o = ~pend_q;
    assign pending_o   = pend_q;
    assign cfg_err_o   = err_q;
    assign mode_o      = mode_q;
    assign delay_o     = delay_q;
    assign phase_o     = phase_q;

    assign accept = cfg_valid_i & ~pend_q;
    assign legal  = mode_is_valid(cfg_mode_i);

    // apply_i needs pend_q=1 and accept needs pend_q=0, so they never overlap.
    always_comb begin
        pend_d = pend_q;
        if (apply_i)
            pend_d = 1'b0;
        else if (accept & legal)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= DEF_MODE_C;
            delay_q <= DEF_DELAY_C;
            phase_q <= DEF_PHASE_C;
        end else begin
            pend_q <= pend_d;
            err_q  <= accept & ~legal;
            if (accept & legal) begin
                mode_q  <= cfg_mode_i;
                delay_q <= cfg_delay_i;
                phase_q <= cfg_phase_i;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Tx frame scheduler: IDLE/RUN/DRAIN/GAP control of the Tx datapath, with
// configuration changes applied only while transmission is off.
// Ports: clk_32M768, rst_32M768 (sync, active-high); start/stop pulses;
// cfg_* request handshake; frame_last end-of-frame pulse; tx_enable and
// active config (MODE_CTRL, DELAY_CNT, TX_PHASE_CONFIG); cfg_err, cfg_applied
// pulses; frame_cnt completed frames; busy when not IDLE.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int          GAP_CYCLES = 64,
    parameter logic [3:0]  DEF_MODE   = DEF_MODE_C,
    parameter logic [3:0]  DEF_DELAY  = DEF_DELAY_C,
    parameter logic [15:0] DEF_PHASE  = DEF_PHASE_C
) (
    input  logic        clk_32M768,
    input  logic        rst_32M768,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_mode,
    input  logic [3:0]  cfg_delay,
    input  logic [15:0] cfg_phase,
    input  logic        frame_last,
    output logic        tx_enable,
    output logic [3:0]  MODE_CTRL,
    output logic [3:0]  DELAY_CNT,
    output logic [15:0] TX_PHASE_CONFIG,
    output logic        cfg_err,
    output logic        cfg_applied,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          stop_req_q, stop_req_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    mode_q, delay_q;
    logic [15:0]   phase_q;
    logic          applied_q;

    logic          pending, apply, stop_seen;
    logic [3:0]    sh_mode, sh_delay;
    logic [15:0]   sh_phase;

    tx_cfg_shadow u_shadow (
        .clk_i       (clk_32M768),
        .rst_i       (rst_32M768),
        .cfg_valid_i (cfg_valid),
        .cfg_mode_i  (cfg_mode),
        .cfg_delay_i (cfg_delay),
        .cfg_phase_i (cfg_phase),
        .apply_i     (apply),
        .cfg_ready_o (cfg_ready),
        .pending_o   (pending),
        .cfg_err_o   (cfg_err),
        .mode_o      (sh_mode),
        .delay_o     (sh_delay),
        .phase_o     (sh_phase)
    );

    assign tx_enable       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign busy            = (state_q != ST_IDLE);
    assign MODE_CTRL       = mode_q;
    assign DELAY_CNT       = delay_q;
    assign TX_PHASE_CONFIG = phase_q;
    assign cfg_applied     = applied_q;
    assign frame_cnt       = cnt_q;

    // Copy happens either while idle or on the edge that leaves DRAIN,
    // so the active config is frozen whenever tx_enable is high.
    assign apply = pending &
                   ((state_q == ST_IDLE) |
                    ((state_q == ST_DRAIN) & frame_last));

    assign stop_seen = stop_req_q | stop;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start & ~stop)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_seen | pending)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_last) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == '0)
                    state_d = stop_seen ? ST_IDLE : ST_RUN;
                else
                    gap_d = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stop is only remembered outside IDLE and is dropped on IDLE entry.
    assign stop_req_d = busy & stop_seen & (state_d != ST_IDLE);

    assign cnt_d = (frame_last & tx_enable) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_q    <= ST_IDLE;
            stop_req_q <= 1'b0;
            gap_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= DEF_MODE;
            delay_q    <= DEF_DELAY;
            phase_q    <= DEF_PHASE;
            applied_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_req_q <= stop_req_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            applied_q  <= apply;
            if (apply) begin
                mode_q  <= sh_mode;
                delay_q <= sh_delay;
                phase_q <= sh_phase;
            end
        end
    end

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 64: inter-frame idle cycles of clk_32M768 between frame end and restart/config apply.
REQ-002 SHALL have parameter DEF_MODE, default 4'b0100 (MIX): MODE_CTRL after reset.
REQ-003 SHALL have parameter DEF_DELAY, default 4'd8: DELAY_CNT after reset.
REQ-004 SHALL have parameter DEF_PHASE, default 16'd8192: TX_PHASE_CONFIG after reset.
REQ-005 SHALL have ports: clk_32M768  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst_32M768  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: start  in  1  begin transmission (pulse); stop  in  1  end transmission after current frame (pulse).
REQ-008 SHALL have ports: cfg_valid  in  1; cfg_ready  out  1; cfg_mode  in  4; cfg_delay  in  4; cfg_phase  in  16 -- configuration request, valid/ready handshake.
REQ-009 SHALL have ports: frame_last  in  1  one-cycle pulse at last symbol of a Tx frame (data_tlast & data_tvalid, already in clk_32M768 domain).
REQ-010 SHALL have ports: tx_enable  out  1; MODE_CTRL  out  4; DELAY_CNT  out  4; TX_PHASE_CONFIG  out  16 -- drive the Tx datapath.
REQ-011 SHALL have ports: cfg_err  out  1  pulse on rejected request; cfg_applied  out  1  pulse on shadow-to-active copy; frame_cnt  out  16  completed frames; busy  out  1  state != IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, GAP; tx_enable=1 in RUN and DRAIN only.
REQ-013 IDLE: start=1 and stop=0 -> RUN next cycle; start and stop both high -> stay IDLE; stop alone ignored.
REQ-014 RUN: stop=1 or shadow pending -> DRAIN next cycle; start ignored in all states except IDLE.
REQ-015 DRAIN: frame_last=1 -> GAP next cycle, gap counter loaded with GAP_CYCLES-1; frame_last in RUN also increments frame_cnt but causes no transition.
REQ-016 GAP: counter decrements each cycle; at 0 -> IDLE if stop latched, else RUN; GAP lasts exactly GAP_CYCLES cycles.
REQ-017 stop SHALL be latched (stop_req) when seen in RUN/DRAIN/GAP and cleared on entry to IDLE.
REQ-018 frame_cnt SHALL increment by 1 on each frame_last while tx_enable=1, wrapping 16'hFFFF -> 0; frame_last with tx_enable=0 ignored.
REQ-019 cfg_ready SHALL be 1 iff no shadow pending; request accepted on cfg_valid & cfg_ready.
REQ-020 Accepted request with cfg_mode not in {0001,0010,0100} SHALL be dropped, cfg_err pulses 1 cycle next cycle, pending unchanged.
REQ-021 Valid accepted request SHALL be stored in shadow registers and set pending the next cycle.
REQ-022 Shadow SHALL be copied to MODE_CTRL/DELAY_CNT/TX_PHASE_CONFIG, pending cleared, cfg_applied pulsed: (a) one cycle after pending set while in IDLE; (b) on the cycle of DRAIN->GAP transition.
REQ-023 Active config outputs SHALL never change while tx_enable=1.
REQ-024 Pending set and start in same IDLE cycle: apply and RUN transition both occur; RUN begins with new config.
REQ-025 cfg_phase width 16 used unmodified; no arithmetic beyond gap down-counter (width clog2(GAP_CYCLES)) and 16-bit frame counter.

Reset
REQ-026 On rst_32M768=1 at clock edge: state=IDLE, tx_enable=0, MODE_CTRL=DEF_MODE, DELAY_CNT=DEF_DELAY, TX_PHASE_CONFIG=DEF_PHASE, pending=0, cfg_ready=1, stop_req=0, cfg_err=0, cfg_applied=0, frame_cnt=0, busy=0.
REQ-027 Reset mid-frame or mid-GAP SHALL discard pending shadow and latched stop with no cfg_applied pulse.

Structure
REQ-028 Mode encodings MODE_BPSK/QPSK/MIX, state encoding and default constants SHALL live in a shared package used by Tx and tx_frame_scheduler.
REQ-029 Config validation (one-hot mode check plus shadow register) SHALL be a sub-module tx_cfg_shadow; FSM and counters stay in top.

Verification
REQ-030 Reset, no stimulus 200 cycles -> MODE_CTRL=0100, DELAY_CNT=8, TX_PHASE_CONFIG=8192, tx_enable=0, cfg_ready=1.
REQ-031 IDLE, cfg {0001,4,4096} -> cfg_applied 2 cycles after handshake, outputs updated; start -> tx_enable=1 next cycle.
REQ-032 RUN, cfg {0010,2,16384} mid-frame -> outputs unchanged, cfg_ready=0, DRAIN; frame_last -> GAP, new config applied, tx_enable=0 exactly 64 cycles, then RUN.
REQ-033 RUN, stop then 3 frame_last pulses -> only first ends transmission; IDLE after 64-cycle GAP; frame_cnt +1 only.
REQ-034 cfg_mode=0011 -> cfg_err pulse 1 cycle, outputs and cfg_ready unchanged; start+stop same IDLE cycle -> stays IDLE.
REQ-035 Preload frame_cnt to 16'hFFFF via 65535 frames (or force) -> next frame_last gives 0; reset during GAP with pending -> IDLE, defaults, no cfg_applied.
